// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// dlsc_pcie_s6_outbound_read_alloc: assigns PCIe tags and read-buffer space to outbound read commands.
// Optional 4 KB boundary splitting is enabled by DLSC_PCIE_S6_READ_ALLOC_SPLIT4K_EN.
module dlsc_pcie_s6_outbound_read_alloc #(
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int TAG  = 5,
    parameter int BUFA = 9
) (
    input  logic            clk,
    input  logic            rst,
    output logic            cmd_ar_ready,
    input  logic            cmd_ar_valid,
    input  logic [ADDR-3:0] cmd_ar_addr,
    input  logic [LEN-1:0]  cmd_ar_len,
    input  logic            req_ready,
    output logic            req_valid,
    output logic [ADDR-3:0] req_addr,
    output logic [LEN-1:0]  req_len,
    output logic [TAG-1:0]  req_tag,
    output logic            alloc_init,
    output logic            alloc_valid,
    output logic [TAG:0]    alloc_tag,
    output logic [BUFA:0]   alloc_bufa,
    input  logic            dealloc_tag,
    input  logic            dealloc_data
);
    typedef enum logic [1:0] {IDLE, CHECK, ALLOC, REQ} state_t;
    state_t          st_q;
    logic            init_q, alloc_valid_q, req_valid_q, rem_q;
    logic [ADDR-3:0] cur_addr_q, req_addr_q;
    logic [LEN-1:0]  cur_len_q, req_len_q, plen;
    logic [TAG-1:0]  req_tag_q;
    logic [TAG:0]    alloc_tag_q, tags_q, tags_d;
    logic [BUFA:0]   alloc_bufa_q, free_q, free_d, pdw;
    logic            ok;
`ifdef DLSC_PCIE_S6_READ_ALLOC_SPLIT4K_EN
    logic [10:0]     span;
    logic            cross;
    logic [ADDR-3:0] nxt_addr;
    logic [LEN-1:0]  nxt_len;
    assign span     = {1'b0, cur_addr_q[9:0]} + 11'(cur_len_q) + 11'd1;
    assign cross    = span > 11'd1024;
    assign plen     = cross ? LEN'(10'd1023 - cur_addr_q[9:0]) : cur_len_q;
    assign nxt_addr = {cur_addr_q[ADDR-3:10] + (ADDR-12)'(1), 10'd0};
    assign nxt_len  = cur_len_q - plen - LEN'(1);
`else
    assign plen = cur_len_q;
`endif
    assign pdw = (BUFA+1)'(plen) + (BUFA+1)'(1);
    // Only registered counters are consulted, so a dealloc becomes visible one cycle later.
    assign ok     = !tags_q[TAG] && (free_q >= pdw);
    assign tags_d = tags_q + (TAG+1)'(alloc_valid_q) - (TAG+1)'(dealloc_tag);
    assign free_d = free_q - (alloc_valid_q ? pdw : '0) + (BUFA+1)'(dealloc_data);
    assign cmd_ar_ready = (st_q == IDLE) && !init_q;
    assign alloc_init   = init_q;
    assign alloc_valid  = alloc_valid_q;
    assign alloc_tag    = alloc_tag_q;
    assign alloc_bufa   = alloc_bufa_q;
    assign req_valid    = req_valid_q;
    assign req_addr     = req_addr_q;
    assign req_len      = req_len_q;
    assign req_tag      = req_tag_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= IDLE;
            init_q        <= 1'b1;
            alloc_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            rem_q         <= 1'b0;
            cur_addr_q    <= '0;
            cur_len_q     <= '0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            req_tag_q     <= '0;
            alloc_tag_q   <= '0;
            alloc_bufa_q  <= '0;
            tags_q        <= '0;
            free_q        <= {1'b1, {BUFA{1'b0}}};
        end else begin
            init_q        <= 1'b0;
            tags_q        <= tags_d;
            free_q        <= free_d;
            alloc_valid_q <= 1'b0;
            case (st_q)
                IDLE: if (cmd_ar_ready && cmd_ar_valid) begin
                    cur_addr_q <= cmd_ar_addr;
                    cur_len_q  <= cmd_ar_len;
                    st_q       <= CHECK;
                end
                CHECK: if (ok) begin
                    alloc_valid_q <= 1'b1;
                    st_q          <= ALLOC;
                end
                ALLOC: begin
                    req_valid_q  <= 1'b1;
                    req_addr_q   <= cur_addr_q;
                    req_len_q    <= plen;
                    req_tag_q    <= alloc_tag_q[TAG-1:0];
                    alloc_tag_q  <= alloc_tag_q + (TAG+1)'(1);
                    alloc_bufa_q <= alloc_bufa_q + pdw;
                    st_q         <= REQ;
`ifdef DLSC_PCIE_S6_READ_ALLOC_SPLIT4K_EN
                    rem_q <= cross;
                    if (cross) begin
                        cur_addr_q <= nxt_addr;
                        cur_len_q  <= nxt_len;
                    end
`endif
                end
                REQ: if (req_ready) begin
                    req_valid_q <= 1'b0;
                    rem_q       <= 1'b0;
                    st_q        <= rem_q ? CHECK : IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dlsc_pcie_s6_outbound_read_alloc.md
# dlsc_pcie_s6_outbound_read_alloc

Assigns a PCIe read tag and a contiguous region of read-data buffer space to each outbound read command. Forwards the tagged request to the TLP request generator. Sits between the outbound read buffer's command output and the request generator. Drives the buffer's allocation port and consumes its tag/dword free feedback, so it never issues a read whose completion could not be stored.

## Interface
- ADDR, 32: byte address width.
- LEN, 4: AXI-style length width (dwords = len+1).
- TAG, 5: PCIe tag width; 2**TAG tags in flight max.
- BUFA, 9: buffer address width; 2**BUFA dwords of buffer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_ar_ready  out  1  command accept.
- cmd_ar_valid  in  1  command valid.
- cmd_ar_addr  in  ADDR-2  dword address.
- cmd_ar_len  in  LEN  length minus one.
- req_ready  in  1  request generator accept.
- req_valid  out  1  tagged request valid.
- req_addr  out  ADDR-2  dword address of piece.
- req_len  out  LEN  piece length minus one.
- req_tag  out  TAG  PCIe tag of piece.
- alloc_init  out  1  high during reset and the first cycle after.
- alloc_valid  out  1  one-cycle tag-memory write strobe.
- alloc_tag  out  TAG+1  tag being/next to be allocated (wrapping sequence number).
- alloc_bufa  out  BUFA+1  buffer start pointer for alloc_tag.
- dealloc_tag  in  1  one tag freed.
- dealloc_data  in  1  one dword freed.

## Operation
- State machine: IDLE, CHECK, ALLOC, REQ.
- IDLE:
  - cmd_ar_ready = (state==IDLE) && !alloc_init, combinational from state.
  - On handshake, latch addr/len into the current-piece registers; go to CHECK.
- CHECK: piece length is resolved per Configuration.
  - Proceed to ALLOC when tags_out < 2**TAG and free_dw >= piece_len+1.
  - Otherwise hold in CHECK.
- ALLOC (one cycle):
  - alloc_valid=1; alloc_tag/alloc_bufa present the current values.
  - req_tag latched = alloc_tag[TAG-1:0].
  - Next cycle: alloc_tag += 1 (mod 2**(TAG+1)), alloc_bufa += piece_len+1 (mod 2**(BUFA+1)), tags_out += 1, free_dw -= piece_len+1.
  - Go to REQ.
- REQ:
  - req_valid=1; outputs stable until req_ready.
  - On accept: if a remainder is pending, load it and go to CHECK; else go to IDLE.
- Counters:
  - tags_out is TAG+1 bits, reset 0; decrements on dealloc_tag.
  - free_dw is BUFA+1 bits, reset 2**BUFA; increments on dealloc_data.
  - Simultaneous alloc and dealloc in one cycle: both applied; net = old − alloc + dealloc.
- CHECK uses registered counter values only; a same-cycle dealloc is seen next cycle.
- Underflow/overflow are impossible by construction. The bench asserts tags_out <= 2**TAG and free_dw <= 2**BUFA.

## Timing
- Reset values: cmd_ar_ready 0, req_valid 0, alloc_valid 0, alloc_tag 0, alloc_bufa 0, alloc_init 1; state IDLE.
- Cycle after rst falls: alloc_init 0 and cmd_ar_ready 1.
- Best-case latency with resources available:
  - cmd handshake at cycle N; CHECK at N+1; alloc_valid at N+2; req_valid at N+3.
- Throughput: at most one piece per 3 cycles.
- req_valid never drops without req_ready; fields never change while req_valid=1 && !req_ready.
- alloc_valid is never asserted in the same cycle as req_valid.
- rst mid-operation: all state returns to reset values; an in-flight piece is discarded. The buffer is reset by the same rst.

## Configuration
- Macro DLSC_PCIE_S6_READ_ALLOC_SPLIT4K_EN.
- Defined: a piece crossing a 4 KB boundary is split at the boundary.
  - Boundary test: addr[11:2] + len + 1 > 1024.
  - First piece len = 1023 − addr[11:2].
  - Remainder addr = next 4 KB base; remainder len = original len − first len − 1.
  - Each piece gets its own tag and contiguous buffer space, so the buffer reads seamlessly across tags.
- Undefined: no split logic. A single piece per command; the upstream guarantees no crossing.

## Test plan
- Single read, addr 0x100 (dword 0x40), len 3 -> one alloc_valid with alloc_tag 0, alloc_bufa 0. Then req {addr 0x40, len 3, tag 0}; alloc_bufa becomes 4.
- TAG=2, 5 len-0 commands, no dealloc -> exactly 4 requests (tags 0..3); 5th held in CHECK. One dealloc_tag -> 5th issues with tag 0, alloc_tag 4.
- BUFA=4, two len-15 commands -> first issued; second waits. 16 dealloc_data pulses -> second allocates with alloc_bufa 16 (wrap bit set).
- SPLIT4K_EN, dword addr 0x3FE, len 3 -> req {0x3FE, len 1, tag 0} then {0x400, len 1, tag 1}. alloc_bufa sequence 0, 2.
- req_ready low for 10 cycles -> req_valid/fields stable; no new alloc. Simultaneous alloc and dealloc_data -> free_dw = old − (len+1) + 1.
- 70 sequential allocs with TAG=5 -> alloc_tag wraps 63→0. Assert rst mid-REQ -> next cycle all outputs at reset values.
